// File: rtl/pipelined_adder.sv
// pipelined_adder: unsigned WIDTH-bit adder split into CHUNK-bit slices, one
// slice per pipeline stage, with valid/ready handshakes on input and output.
// Each transaction carries its own partial sum, inter-slice carry and the
// operand slices still to be added, so transactions never mix.
// Optional feature macro: PIPELINED_ADDER_SAT_EN (saturate sum to all-ones
// when the final carry is set; cout still reports the carry).
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STAGES = WIDTH / CHUNK;

`ifdef PIPELINED_ADDER_SAT_EN
    // Clamp an overflowing result to the largest representable value.
    function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] raw,
                                                 input logic             carry);
        return carry ? {WIDTH{1'b1}} : raw;
    endfunction
`endif

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // Operand bits still to be added when a transaction enters stage s.
        localparam int REM_W = WIDTH - s * CHUNK;
        // Sum bits known once stage s has added its slice.
        localparam int OUT_W = (s + 1) * CHUNK;

        logic             src_vld;
        logic             src_c;
        logic [REM_W-1:0] src_a;
        logic [REM_W-1:0] src_b;
        logic [CHUNK:0]   slice_add;
        logic [OUT_W-1:0] part_d;
        logic [OUT_W-1:0] fin_d;
        logic             adv;

        logic             vld_q;
        logic             carry_q;
        logic [OUT_W-1:0] part_q;

        // ---- stage boundary: source of this stage (input port or previous stage)
        if (s == 0) begin : g_src
            assign src_vld = in_valid;
            assign src_c   = cin;
            assign src_a   = a;
            assign src_b   = b;
            assign part_d  = slice_add[CHUNK-1:0];
        end else begin : g_src
            assign src_vld = g_stage[s-1].vld_q;
            assign src_c   = g_stage[s-1].carry_q;
            assign src_a   = g_stage[s-1].g_rem.rem_a_q;
            assign src_b   = g_stage[s-1].g_rem.rem_b_q;
            assign part_d  = {slice_add[CHUNK-1:0], g_stage[s-1].part_q};
        end

        // One CHUNK+1 bit add per stage; the MSB is the carry to the next slice.
        assign slice_add = {1'b0, src_a[CHUNK-1:0]}
                         + {1'b0, src_b[CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, src_c};

        // Ready chain: a stage may take new contents when it is empty or
        // when everything downstream of it can move this cycle.
        if (s == STAGES - 1) begin : g_fin
`ifdef PIPELINED_ADDER_SAT_EN
            assign fin_d = sat_sum(part_d, slice_add[CHUNK]);
`else
            assign fin_d = part_d;
`endif
            assign adv = !vld_q || out_ready;
        end else begin : g_fin
            assign fin_d = part_d;
            assign adv   = !vld_q || g_stage[s+1].adv;
        end

        // Stage control and partial-sum register; holds while downstream stalls.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q   <= 1'b0;
                carry_q <= 1'b0;
                part_q  <= '0;
            end else if (adv) begin
                vld_q   <= src_vld;
                carry_q <= slice_add[CHUNK];
                part_q  <= fin_d;
            end
        end

        if (s < STAGES - 1) begin : g_rem
            logic [REM_W-CHUNK-1:0] rem_a_q;
            logic [REM_W-CHUNK-1:0] rem_b_q;

            // Operand slices not yet added travel with their transaction.
            always_ff @(posedge clk) begin
                if (adv) begin
                    rem_a_q <= src_a[REM_W-1:CHUNK];
                    rem_b_q <= src_b[REM_W-1:CHUNK];
                end
            end
        end
    end

    // ---- stage boundary: output side of the last stage
    assign in_ready  = g_stage[0].adv;
    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].part_q;
    assign cout      = g_stage[STAGES-1].carry_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed checks of pipelined_adder
// against a plain-arithmetic reference model with an in-order queue.
module tb_pipelined_adder;

    parameter int WIDTH = 32;
    parameter int CHUNK = 8;
    localparam int STAGES = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int vectors     = 0;
    int miscompares = 0;

    // Expected {cout, sum} of every accepted transaction, oldest first.
    logic [WIDTH:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
    );

    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             c);
        logic [WIDTH:0] t;
        t = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
`ifdef PIPELINED_ADDER_SAT_EN
        if (t[WIDTH]) t[WIDTH-1:0] = {WIDTH{1'b1}};
`endif
        return t;
    endfunction

    function automatic logic [WIDTH-1:0] rand_w();
        logic [WIDTH+31:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i += 32) r = (r << 32) | (WIDTH+32)'($urandom);
        case ($urandom_range(0, 7))
            0:       return {WIDTH{1'b1}};
            1:       return '0;
            default: return r[WIDTH-1:0];
        endcase
    endfunction

    task automatic new_vector();
        a   = rand_w();
        b   = rand_w();
        cin = 1'($urandom_range(0, 1));
    endtask

    // One clock: sample handshake/outputs on the falling edge, record accepts
    // in the model, then advance to just after the next rising edge.
    task automatic tick(output bit acc, output bit drn, output bit ov,
                        output bit rdy, output logic [WIDTH:0] got);
        @(negedge clk);
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        ov  = out_valid;
        rdy = in_ready;
        got = {cout, sum};
        if (acc) exp_q.push_back(ref_sum(a, b, cin));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, cout, sum} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b cout=%b sum=%h required all 0", out_valid, cout, sum);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] da[3], db[3], es[3];
        logic             dc[3], ec[3];
        logic [WIDTH-1:0] e3;
        logic [WIDTH:0]   got, pop;
        bit               acc, drn, ov, rdy;
        int               first;
        e3 = '0;
        e3[WIDTH-8] = 1'b1;
        da[0] = WIDTH'(3);          db[0] = WIDTH'(4); dc[0] = 1'b0; es[0] = WIDTH'(7); ec[0] = 1'b0;
        da[1] = {WIDTH{1'b1}};      db[1] = WIDTH'(1); dc[1] = 1'b0; ec[1] = 1'b1;
`ifdef PIPELINED_ADDER_SAT_EN
        es[1] = {WIDTH{1'b1}};
`else
        es[1] = '0;
`endif
        da[2] = {WIDTH{1'b1}} >> 8; db[2] = '0;        dc[2] = 1'b1; es[2] = e3;       ec[2] = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = da[k]; b = db[k]; cin = dc[k]; in_valid = 1'b1;
            tick(acc, drn, ov, rdy, got);
            in_valid = 1'b0;
            vectors++;
            if (!acc) begin
                miscompares++;
                $display("FAIL single_accept[%0d]: got 0 required 1", k);
            end
            first = -1;
            for (int t = 1; t <= STAGES + 3; t++) begin
                tick(acc, drn, ov, rdy, got);
                if (drn) begin
                    if (first < 0) first = t;
                    if (exp_q.size() > 0) pop = exp_q.pop_front();
                    vectors++;
                    if (got !== {ec[k], es[k]}) begin
                        miscompares++;
                        $display("FAIL single_value[%0d]: got cout=%b sum=%h required cout=%b sum=%h",
                                 k, got[WIDTH], got[WIDTH-1:0], ec[k], es[k]);
                    end
                end
            end
            vectors++;
            if (first != STAGES) begin
                miscompares++;
                $display("FAIL single_latency[%0d]: got %0d required %0d", k, first, STAGES);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0] got, exp;
        bit             acc, drn, ov, rdy;
        int             prev, ndrn;
        prev = -1; ndrn = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 16 + STAGES + 4; t++) begin
            in_valid = (t < 16);
            if (t < 16) new_vector();
            tick(acc, drn, ov, rdy, got);
            if (t < 16) begin
                vectors++;
                if (!acc) begin
                    miscompares++;
                    $display("FAIL b2b_accept[%0d]: got 0 required 1", t);
                end
            end
            if (drn) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra: got sum=%h required no output", got[WIDTH-1:0]);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL b2b_value: got %h required %h", got, exp);
                    end
                end
                vectors++;
                if (prev >= 0 && t != prev + 1) begin
                    miscompares++;
                    $display("FAIL b2b_gap: got cycle %0d required %0d", t, prev + 1);
                end
                prev = t;
                ndrn++;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (ndrn != 16) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d required 16", ndrn);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH:0] got, exp, held;
        bit             acc, drn, ov, rdy, have_held;
        int             nacc, ndrn;
        nacc = 0; ndrn = 0; have_held = 1'b0; held = '0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        new_vector();
        for (int t = 0; t < 10; t++) begin
            tick(acc, drn, ov, rdy, got);
            if (acc) begin
                nacc++;
                new_vector();
            end
            if (ov) begin
                if (have_held) begin
                    vectors++;
                    if (got !== held) begin
                        miscompares++;
                        $display("FAIL stall_stable: got %h required %h", got, held);
                    end
                end
                held = got;
                have_held = 1'b1;
            end
        end
        vectors++;
        if (nacc != STAGES) begin
            miscompares++;
            $display("FAIL stall_accepts: got %0d required %0d", nacc, STAGES);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_in_ready: got %b required 0", in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < STAGES + 3; t++) begin
            tick(acc, drn, ov, rdy, got);
            if (drn) begin
                ndrn++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL drain_extra: got sum=%h required no output", got[WIDTH-1:0]);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL drain_value: got %h required %h", got, exp);
                    end
                end
            end
        end
        vectors++;
        if (ndrn != STAGES) begin
            miscompares++;
            $display("FAIL drain_count: got %0d required %0d", ndrn, STAGES);
        end
    endtask

    task automatic test_reset_midstream();
        logic [WIDTH:0] got;
        bit             acc, drn, ov, rdy;
        int             n;
        n = (STAGES < 3) ? STAGES : 3;
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            new_vector();
            tick(acc, drn, ov, rdy, got);
            vectors++;
            if (!acc) begin
                miscompares++;
                $display("FAIL midrst_accept[%0d]: got 0 required 1", i);
            end
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick(acc, drn, ov, rdy, got);
        rst_n = 1'b1;
        exp_q.delete();
        vectors++;
        if ({out_valid, cout, sum} !== '0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_state: got valid=%b cout=%b sum=%h ready=%b required 0/0/0/1",
                     out_valid, cout, sum, in_ready);
        end
        out_ready = 1'b1;
        for (int t = 0; t < STAGES + 6; t++) begin
            tick(acc, drn, ov, rdy, got);
            vectors++;
            if (ov) begin
                miscompares++;
                $display("FAIL midrst_leak: got out_valid=1 sum=%h required 0", got[WIDTH-1:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH:0] got, exp;
        bit             acc, drn, ov, rdy, exp_rdy;
        int             occ;
        in_valid = 1'b0;
        for (int t = 0; t < 400; t++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            occ = exp_q.size();
            exp_rdy = (occ < STAGES) || out_ready;
            tick(acc, drn, ov, rdy, got);
            vectors++;
            if (rdy != exp_rdy) begin
                miscompares++;
                $display("FAIL rand_in_ready: got %b required %b (occupancy %0d)", rdy, exp_rdy, occ);
            end
            if (drn) begin
                vectors++;
                if (occ == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra: got sum=%h required no output", got[WIDTH-1:0]);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL rand_value: got %h required %h", got, exp);
                    end
                end
            end
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 9) < 7);
                new_vector();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < STAGES + 3; t++) begin
            tick(acc, drn, ov, rdy, got);
            if (drn) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_drain_extra: got sum=%h required no output", got[WIDTH-1:0]);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL rand_drain_value: got %h required %h", got, exp);
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rand_lost: got %0d results outstanding required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
